// File: rtl/core_req_demux_pkg.sv
// Shared types for the core request demultiplexer: target port ids, address
// decode rules and the rule-match helper used by the decoder.
package core_req_demux_pkg;

    // Port ids are stored at a fixed width so the id FIFO type does not depend
    // on the top-level parameters. This supports up to CRD_MAX_PORTS targets.
    localparam int unsigned CRD_MAX_PORTS  = 16;
    localparam int unsigned CRD_MAX_ADDR_W = 64;

    typedef logic [$clog2(CRD_MAX_PORTS)-1:0] port_id_t;
    typedef logic [CRD_MAX_ADDR_W-1:0]        rule_addr_t;

    typedef struct packed {
        rule_addr_t base;
        rule_addr_t mask;
    } addr_rule_t;

    // A rule with an all-zero mask is disabled and never matches.
    function automatic logic rule_hit(input addr_rule_t rule, input rule_addr_t addr);
        return (rule.mask != '0) && ((addr & rule.mask) == (rule.base & rule.mask));
    endfunction

endpackage

// File: rtl/core_req_demux_if.sv
// Core-side load/store bus of the request demultiplexer.
//
// Handshakes: a request transfers in a cycle where data_req_i and data_gnt_o
// are both high; the core may change or drop the request when it is not
// granted. A response transfers in a cycle where data_r_valid_o and
// data_r_ready_i are both high; while valid is high and ready is low the
// response fields stay stable and the response is not consumed.
// Signal names carry the direction seen from the demultiplexer.
interface core_req_demux_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  data_req_i;
    logic [ADDR_WIDTH-1:0] data_add_i;
    logic                  data_we_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic [BE_WIDTH-1:0]   data_be_i;
    logic                  data_gnt_o;
    logic                  stall_i;
    logic                  flush_i;
    logic                  data_r_valid_o;
    logic                  data_r_ready_i;
    logic [DATA_WIDTH-1:0] data_r_rdata_o;
    logic                  data_r_opc_o;
    logic                  data_busy_o;

    // Core (LSU) side.
    modport master (
        output data_req_i, data_add_i, data_we_i, data_wdata_i, data_be_i,
        output stall_i, flush_i, data_r_ready_i,
        input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_busy_o
    );

    // Demultiplexer side.
    modport slave (
        input  data_req_i, data_add_i, data_we_i, data_wdata_i, data_be_i,
        input  stall_i, flush_i, data_r_ready_i,
        output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_busy_o
    );
endinterface

// File: rtl/core_req_demux_id_fifo.sv
// Synchronous FIFO of target port ids. Records the target of every granted
// request so responses can be returned in issue order. Push when full and pop
// when empty are ignored, so the count never wraps.
module core_req_demux_id_fifo
    import core_req_demux_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  port_id_t         push_id_i,
    input  logic             pop_i,
    output port_id_t         head_id_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    port_id_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_id_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state pointers and occupancy; simultaneous push and pop keep the count.
    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/core_req_demux.sv
// Core-side request demultiplexer. Routes the core load/store stream to one of
// NUM_PORTS targets by address rule with zero added latency, keeps the target
// of every accepted request in an order FIFO and returns responses to the core
// strictly in issue order. NUM_PORTS must not exceed CRD_MAX_PORTS and
// ADDR_WIDTH must not exceed CRD_MAX_ADDR_W.
module core_req_demux
    import core_req_demux_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] ADDR_BASE = '0,
    parameter logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] ADDR_MASK = '0,
    parameter int unsigned DEFAULT_PORT    = NUM_PORTS - 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    core_req_demux_if.slave                       core,
    output logic [NUM_PORTS-1:0]                  port_req_o,
    input  logic [NUM_PORTS-1:0]                  port_gnt_i,
    output logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_add_o,
    output logic [NUM_PORTS-1:0]                  port_we_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_wdata_o,
    output logic [NUM_PORTS-1:0][BE_WIDTH-1:0]    port_be_o,
    input  logic [NUM_PORTS-1:0]                  port_r_valid_i,
    output logic [NUM_PORTS-1:0]                  port_r_ready_o,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_r_rdata_i,
    input  logic [NUM_PORTS-1:0]                  port_r_opc_i,
    output logic [NUM_PORTS-1:0]                  conflicts_o
);

    localparam int unsigned ID_W  = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    addr_rule_t       rules [NUM_PORTS];
    logic [ID_W-1:0]  sel_idx;
    logic [ID_W-1:0]  head_idx;
    port_id_t         head_id;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] outstanding;
    logic             issue_ok;
    logic             push, pop;
    logic             resp_live;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rule
        assign rules[p] = '{base: CRD_MAX_ADDR_W'(ADDR_BASE[p]),
                            mask: CRD_MAX_ADDR_W'(ADDR_MASK[p])};
    end

    // Address decode: scanning from the top down lets the lowest matching port win.
    always_comb begin
        sel_idx = ID_W'(DEFAULT_PORT);
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (rule_hit(rules[p], CRD_MAX_ADDR_W'(core.data_add_i))) begin
                sel_idx = ID_W'(p);
            end
        end
    end

    // A full order FIFO blocks issue even if a response pops in the same cycle.
    assign issue_ok        = ~rst & core.data_req_i & ~core.stall_i & ~core.flush_i & ~fifo_full;
    assign core.data_gnt_o = issue_ok & port_gnt_i[sel_idx];
    assign push            = core.data_gnt_o;

    // Request strobe goes only to the selected target.
    always_comb begin
        port_req_o          = '0;
        port_req_o[sel_idx] = issue_ok;
    end

    assign conflicts_o  = port_req_o & ~port_gnt_i;
    assign port_add_o   = {NUM_PORTS{core.data_add_i}};
    assign port_we_o    = {NUM_PORTS{core.data_we_i}};
    assign port_wdata_o = {NUM_PORTS{core.data_wdata_i}};
    assign port_be_o    = {NUM_PORTS{core.data_be_i}};

    core_req_demux_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .push_id_i (port_id_t'(sel_idx)),
        .pop_i     (pop),
        .head_id_o (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (outstanding)
    );

    // Only the oldest outstanding target may answer; younger targets hold r_valid.
    assign head_idx  = ID_W'(head_id);
    assign resp_live = ~rst & ~fifo_empty;

    assign core.data_r_valid_o = resp_live & port_r_valid_i[head_idx];
    assign core.data_r_rdata_o = port_r_rdata_i[head_idx];
    assign core.data_r_opc_o   = port_r_opc_i[head_idx];
    assign core.data_busy_o    = ~rst & (outstanding != '0);
    assign pop                 = core.data_r_valid_o & core.data_r_ready_i;

    // Ready is steered to the head target only.
    always_comb begin
        port_r_ready_o           = '0;
        port_r_ready_o[head_idx] = resp_live & core.data_r_ready_i;
    end

endmodule

// File: tb/tb_core_req_demux.sv
// Bench for core_req_demux: behavioural targets with per-request latency, a
// reference model (queue of outstanding target ports plus expected-response
// queue), a decode vector table, directed ordering/backpressure/flush/reset
// sequences and a randomized phase.
module tb_core_req_demux;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MO = 4;
    // Port 0: 0x1xxx_xxxx. Port 1 overlaps port 0 on 0x10xx_xxxx (port 0 must win)
    // and otherwise receives everything as the default port.
    localparam logic [NP-1:0][AW-1:0] BASE = {32'h1000_0000, 32'h1000_0000};
    localparam logic [NP-1:0][AW-1:0] MASK = {32'hFF00_0000, 32'hF000_0000};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_req_demux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    logic [NP-1:0]         port_req_o, port_gnt_i, port_we_o, port_r_valid_i;
    logic [NP-1:0]         port_r_ready_o, port_r_opc_i, conflicts_o;
    logic [NP-1:0][AW-1:0] port_add_o;
    logic [NP-1:0][DW-1:0] port_wdata_o, port_r_rdata_i;
    logic [NP-1:0][BW-1:0] port_be_o;

    core_req_demux #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .MAX_OUTSTANDING(MO), .ADDR_BASE(BASE), .ADDR_MASK(MASK), .DEFAULT_PORT(NP - 1)
    ) dut (
        .clk(clk), .rst(rst), .core(bus),
        .port_req_o(port_req_o), .port_gnt_i(port_gnt_i), .port_add_o(port_add_o),
        .port_we_o(port_we_o), .port_wdata_o(port_wdata_o), .port_be_o(port_be_o),
        .port_r_valid_i(port_r_valid_i), .port_r_ready_o(port_r_ready_o),
        .port_r_rdata_i(port_r_rdata_i), .port_r_opc_i(port_r_opc_i),
        .conflicts_o(conflicts_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [31:0] due;
        logic [32:0] rsp;
    } tgt_rsp_t;

    tgt_rsp_t    tq [NP][$];   // per-target pending responses, in acceptance order
    int          order_q[$];   // reference: target of each outstanding request
    logic [32:0] exp_q[$];     // reference: {opc,rdata} expected at the core, issue order
    int          dlv_q[$];     // target port of each response the DUT delivered
    int          lat_fix [NP];
    bit          tgt_en;

    int          e_sel;
    logic        e_issue, e_gnt, e_busy, e_rv, e_pop;
    logic [NP-1:0] e_req, e_conf, e_rrdy;
    logic [NP-1:0] c_req, c_gnt_i, c_rdy, c_rvi;
    logic          c_rv, c_ready;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ref_route(input logic [AW-1:0] a);
        for (int p = 0; p < NP; p++) begin
            if (MASK[p] != '0 && (a & MASK[p]) == (BASE[p] & MASK[p])) return p;
        end
        return NP - 1;
    endfunction

    // Drive target responses, then compare every DUT output with the reference.
    task automatic settle();
        for (int p = 0; p < NP; p++) begin
            if (tgt_en && tq[p].size() > 0 && tq[p][0].due <= cyc) begin
                port_r_valid_i[p] = 1'b1;
                port_r_rdata_i[p] = tq[p][0].rsp[31:0];
                port_r_opc_i[p]   = tq[p][0].rsp[32];
            end else begin
                port_r_valid_i[p] = 1'b0;
                port_r_rdata_i[p] = 32'hDEAD_0000 | p;
                port_r_opc_i[p]   = 1'b0;
            end
        end
        #1;
        e_sel   = ref_route(bus.data_add_i);
        e_issue = !rst && bus.data_req_i && !bus.stall_i && !bus.flush_i && order_q.size() < MO;
        e_gnt   = e_issue && port_gnt_i[e_sel];
        e_req   = '0;
        if (e_issue) e_req[e_sel] = 1'b1;
        e_conf  = e_req & ~port_gnt_i;
        e_busy  = !rst && order_q.size() > 0;
        e_rv    = 1'b0;
        e_rrdy  = '0;
        if (e_busy) begin
            e_rv = port_r_valid_i[order_q[0]];
            e_rrdy[order_q[0]] = bus.data_r_ready_i;
        end
        e_pop = e_rv && bus.data_r_ready_i;
        chk("gnt", bus.data_gnt_o, e_gnt);
        chk("port_req", port_req_o, e_req);
        chk("conflicts", conflicts_o, e_conf);
        chk("r_valid", bus.data_r_valid_o, e_rv);
        chk("port_r_ready", port_r_ready_o, e_rrdy);
        chk("busy", bus.data_busy_o, e_busy);
        if (e_rv) begin
            chk("rdata", bus.data_r_rdata_o, exp_q[0][31:0]);
            chk("opc", bus.data_r_opc_o, exp_q[0][32]);
        end
        if (e_issue) begin
            for (int p = 0; p < NP; p++) begin
                chk("bcast_add", port_add_o[p], bus.data_add_i);
                chk("bcast_wdata", port_wdata_o[p], bus.data_wdata_i);
                chk("bcast_we_be", {port_we_o[p], port_be_o[p]}, {bus.data_we_i, bus.data_be_i});
            end
        end
        c_req   = port_req_o;
        c_gnt_i = port_gnt_i;
        c_rdy   = port_r_ready_o;
        c_rvi   = port_r_valid_i;
        c_rv    = bus.data_r_valid_o;
        c_ready = bus.data_r_ready_i;
    endtask

    // Clock edge: targets react to what the DUT drove, reference advances.
    task automatic advance();
        logic [32:0] nd;
        int lat;
        nd = {($urandom_range(0, 7) == 0), $urandom()};
        @(posedge clk);
        if (rst) begin
            for (int p = 0; p < NP; p++) tq[p].delete();
            order_q.delete();
            exp_q.delete();
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (c_rdy[p] && c_rvi[p]) begin
                    void'(tq[p].pop_front());
                    if (c_rv && c_ready) dlv_q.push_back(p);
                end
                if (c_req[p] && c_gnt_i[p]) begin
                    lat = (lat_fix[p] > 0) ? lat_fix[p] : int'($urandom_range(1, 6));
                    tq[p].push_back('{due: 32'(cyc + lat), rsp: nd});
                end
            end
            if (e_pop) begin
                void'(order_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (e_gnt) begin
                order_q.push_back(e_sel);
                exp_q.push_back(nd);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle();
        bus.data_req_i     = 1'b0;
        bus.stall_i        = 1'b0;
        bus.flush_i        = 1'b0;
        bus.data_r_ready_i = 1'b1;
        port_gnt_i         = 2'b11;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [NP-1:0] g);
        bus.data_req_i   = 1'b1;
        bus.data_add_i   = a;
        bus.data_we_i    = 1'($urandom_range(0, 1));
        bus.data_wdata_i = $urandom();
        bus.data_be_i    = 4'($urandom_range(0, 15));
        port_gnt_i       = g;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        tgt_en = 1'b1;
        while ((order_q.size() != 0 || tq[0].size() != 0 || tq[1].size() != 0) && n < 60) begin
            step();
            n++;
        end
        chk("drain_done", (n < 60), 1);
    endtask

    typedef struct packed {
        logic          req;
        logic [AW-1:0] addr;
        logic          stall;
        logic          flush;
        logic [NP-1:0] gnt;
        logic [NP-1:0] exp_req;
        logic          exp_gnt;
        logic [NP-1:0] exp_conf;
    } vec_t;

    vec_t vt [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        logic        got;
        int          n;

        vt[0] = '{1'b1, 32'h1000_0000, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b01};
        vt[1] = '{1'b1, 32'h2000_0000, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b10};
        vt[2] = '{1'b1, 32'h10FF_0000, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b01};
        vt[3] = '{1'b1, 32'h0000_0040, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b10};
        vt[4] = '{1'b1, 32'h1000_0004, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00};
        vt[5] = '{1'b1, 32'h2000_0000, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 2'b00};
        vt[6] = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'b00};
        vt[7] = '{1'b1, 32'hF000_0000, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 2'b10};
        vt[8] = '{1'b1, 32'hF000_0000, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 2'b00};
        vt[9] = '{1'b0, 32'h1000_0000, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00};

        // Clock/reset
        rst = 1'b1;
        tgt_en = 1'b1;
        lat_fix[0] = 1;
        lat_fix[1] = 1;
        bus.data_add_i = '0;
        bus.data_we_i = 1'b0;
        bus.data_wdata_i = '0;
        bus.data_be_i = '0;
        port_r_valid_i = '0;
        port_r_rdata_i = '0;
        port_r_opc_i = '0;
        idle();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();

        // Decode / issue vector table
        for (int i = 0; i < 10; i++) begin
            issue(vt[i].addr, vt[i].gnt);
            bus.data_req_i = vt[i].req;
            bus.stall_i    = vt[i].stall;
            bus.flush_i    = vt[i].flush;
            settle();
            chk($sformatf("tbl%0d_req", i), port_req_o, vt[i].exp_req);
            chk($sformatf("tbl%0d_gnt", i), bus.data_gnt_o, vt[i].exp_gnt);
            chk($sformatf("tbl%0d_conf", i), conflicts_o, vt[i].exp_conf);
            advance();
        end
        drain();

        // T1: single load to port 0, response next cycle
        issue(32'h1000_0010, 2'b01);
        settle();
        chk("t1_gnt", bus.data_gnt_o, 1);
        chk("t1_busy_idle", bus.data_busy_o, 0);
        advance();
        idle();
        settle();
        chk("t1_rvalid", bus.data_r_valid_o, 1);
        chk("t1_busy", bus.data_busy_o, 1);
        advance();
        settle();
        chk("t1_busy_after", bus.data_busy_o, 0);
        advance();

        // T2: slow port 1 issued first holds back the fast port 0 response
        drain();
        dlv_q.delete();
        lat_fix[1] = 5;
        issue(32'h2000_0000, 2'b11);
        step();
        issue(32'h1000_0000, 2'b11);
        step();
        idle();
        settle();
        chk("t2_p0_ready_valid", port_r_valid_i[0], 1);
        chk("t2_hold_rvalid", bus.data_r_valid_o, 0);
        chk("t2_hold_rdy0", port_r_ready_o[0], 0);
        advance();
        n = 0;
        while (dlv_q.size() < 2 && n < 20) begin
            step();
            n++;
        end
        chk("t2_count", dlv_q.size(), 2);
        if (dlv_q.size() == 2) begin
            chk("t2_first_port", dlv_q[0], 1);
            chk("t2_second_port", dlv_q[1], 0);
        end
        lat_fix[1] = 1;

        // T3: fill the order FIFO, then pop one and resume
        drain();
        tgt_en = 1'b0;
        for (int k = 0; k < MO; k++) begin
            issue((k % 2 == 0) ? 32'h1000_0100 : 32'h3000_0100, 2'b11);
            settle();
            chk($sformatf("t3_gnt%0d", k), bus.data_gnt_o, 1);
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            issue(32'h1000_0200, 2'b11);
            settle();
            chk("t3_full_gnt", bus.data_gnt_o, 0);
            chk("t3_full_req", port_req_o, 0);
            advance();
        end
        tgt_en = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 12) begin
            settle();
            got = bus.data_gnt_o;
            advance();
            n++;
        end
        chk("t3_resume", got, 1);
        chk("t3_resume_not_same_cycle", (n >= 2), 1);

        // T4: core holds ready low with a valid response
        drain();
        issue(32'h1000_0300, 2'b01);
        step();
        idle();
        bus.data_r_ready_i = 1'b0;
        held = '0;
        for (int k = 0; k < 3; k++) begin
            settle();
            if (k == 0) held = bus.data_r_rdata_o;
            chk("t4_rvalid", bus.data_r_valid_o, 1);
            chk("t4_rdata_stable", bus.data_r_rdata_o, held);
            chk("t4_no_port_ready", port_r_ready_o, 0);
            chk("t4_busy", bus.data_busy_o, 1);
            advance();
        end
        bus.data_r_ready_i = 1'b1;

        // T5: flush blocks issue, the pending response still returns
        drain();
        lat_fix[0] = 2;
        issue(32'h1000_0400, 2'b01);
        step();
        issue(32'h2000_0400, 2'b11);
        bus.flush_i = 1'b1;
        bus.data_r_ready_i = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("t5_req", port_req_o, 0);
            chk("t5_gnt", bus.data_gnt_o, 0);
            if (bus.data_r_valid_o) got = 1'b1;
            advance();
        end
        chk("t5_delivered", got, 1);
        lat_fix[0] = 1;

        // T6: reset with two outstanding requests
        drain();
        tgt_en = 1'b0;
        issue(32'h1000_0500, 2'b11);
        step();
        issue(32'h2000_0500, 2'b11);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tgt_en = 1'b1;
        settle();
        chk("t6_busy", bus.data_busy_o, 0);
        chk("t6_rvalid", bus.data_r_valid_o, 0);
        advance();
        issue(32'h1000_0600, 2'b01);
        settle();
        chk("t6_new_gnt", bus.data_gnt_o, 1);
        advance();
        drain();

        // Randomized traffic
        lat_fix[0] = 0;
        lat_fix[1] = 0;
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] a;
            a = $urandom();
            case ($urandom_range(0, 2))
                0:       a = {4'h1, a[27:0]};
                1:       a = {8'h10, a[23:0]};
                default: a = a;
            endcase
            issue(a, 2'($urandom_range(0, 3)));
            bus.data_req_i     = ($urandom_range(0, 9) < 7);
            bus.stall_i        = ($urandom_range(0, 9) == 0);
            bus.flush_i        = ($urandom_range(0, 19) == 0);
            bus.data_r_ready_i = ($urandom_range(0, 9) < 7);
            rst                = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        lat_fix[0] = 1;
        lat_fix[1] = 1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
